// File: rtl/lif_array.sv
// lif_array: N parallel leaky integrate-and-fire neurons with per-neuron
// programmable threshold and refractory period, reset-on-spike, saturating
// integration and registered spike outputs.
// Optional build macro: LIF_SPIKE_COUNT_EN adds a saturating 8-bit spike
// counter per neuron on cnt_out; without it cnt_out is tied to zero.
module lif_array #(
    parameter int N_NEURONS      = 4,
    parameter int WIDTH          = 8,
    parameter int LEAK_SHIFT     = 1,
    parameter int REFRAC_W       = 4,
    parameter int DEFAULT_THRESH = 32,
    parameter int DEFAULT_REFRAC = 2
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                en,
    input  logic [N_NEURONS*WIDTH-1:0]                          current,
    input  logic                                                cfg_we,
    input  logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)-1:0] cfg_addr,
    input  logic                                                cfg_sel,
    input  logic [WIDTH-1:0]                                    cfg_data,
    output logic [N_NEURONS-1:0]                                spike,
    output logic [N_NEURONS*WIDTH-1:0]                          state_out,
    output logic [N_NEURONS*8-1:0]                              cnt_out
);

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
        logic [WIDTH-1:0]    state_q;
        logic [WIDTH-1:0]    thresh_q;
        logic [REFRAC_W-1:0] refrac_q;
        logic [REFRAC_W-1:0] period_q;
        logic                spike_q;
        logic [WIDTH-1:0]    cur_i;
        logic [WIDTH-1:0]    leaked;
        logic [WIDTH:0]      sum_wide;
        logic [WIDTH-1:0]    sum_sat;
        logic                fire;
        logic                cfg_hit;

        // Leak, integrate and clamp; one extra bit catches the overflow.
        // An out-of-range cfg_addr never equals any neuron index, so it is dropped.
        assign cur_i    = current[i*WIDTH +: WIDTH];
        assign leaked   = state_q >> LEAK_SHIFT;
        assign sum_wide = {1'b0, cur_i} + {1'b0, leaked};
        assign sum_sat  = sum_wide[WIDTH] ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];
        assign fire     = (refrac_q == '0) && (sum_sat >= thresh_q);
        assign cfg_hit  = cfg_we && (int'(cfg_addr) == i);

        // Configuration registers; writes land on the edge, so a same-edge update sees the old value.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                thresh_q <= WIDTH'(DEFAULT_THRESH);
                period_q <= REFRAC_W'(DEFAULT_REFRAC);
            end else if (cfg_hit) begin
                if (cfg_sel) begin
                    period_q <= cfg_data[REFRAC_W-1:0];
                end else begin
                    thresh_q <= cfg_data;
                end
            end
        end

        // Membrane, refractory countdown and spike pulse; en low freezes state and drops spike.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q  <= '0;
                refrac_q <= '0;
                spike_q  <= 1'b0;
            end else if (!en) begin
                spike_q <= 1'b0;
            end else if (refrac_q != '0) begin
                state_q  <= '0;
                refrac_q <= refrac_q - 1'b1;
                spike_q  <= 1'b0;
            end else if (fire) begin
                state_q  <= '0;
                refrac_q <= period_q;
                spike_q  <= 1'b1;
            end else begin
                state_q <= sum_sat;
                spike_q <= 1'b0;
            end
        end

        assign spike[i]                   = spike_q;
        assign state_out[i*WIDTH +: WIDTH] = state_q;

`ifdef LIF_SPIKE_COUNT_EN
        logic [7:0] cnt_q;

        // Saturating count of spikes fired since reset.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (en && fire && (cnt_q != 8'hFF)) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end

        assign cnt_out[i*8 +: 8] = cnt_q;
`endif
    end

`ifndef LIF_SPIKE_COUNT_EN
    assign cnt_out = '0;
`endif

endmodule

// File: tb/tb_lif_array.sv
// tb_lif_array: directed scoreboard bench for lif_array (3 neurons, 8-bit).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_lif_array;

    typedef struct {
        string       name;
        logic [2:0]  spk;
        logic [23:0] st;
        logic [23:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [23:0] current = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic        cfg_sel = 1'b0;
    logic [7:0]  cfg_data = '0;
    logic [2:0]  spike;
    logic [23:0] state_out;
    logic [23:0] cnt_out;

    exp_t sb[$];
    int   nChecks = 0;
    int   nFails  = 0;

    lif_array #(
        .N_NEURONS(3), .WIDTH(8), .LEAK_SHIFT(1), .REFRAC_W(4),
        .DEFAULT_THRESH(32), .DEFAULT_REFRAC(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .current(current),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .spike(spike), .state_out(state_out), .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] st3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [23:0] cnt3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
`ifdef LIF_SPIKE_COUNT_EN
        return {c, b, a};
`else
        return (a & b & c & 8'h00) == 8'h00 ? 24'h0 : 24'h0;
`endif
    endfunction

    task automatic checkOutput(input string nm, input string field, input logic [23:0] act, input logic [23:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s.%s got 0x%06h expected 0x%06h", nm, field, act, req);
        end
    endtask

    // One edge of stimulus; expectation describes outputs after that edge.
    task automatic applyStimulus(
        input logic r, input logic e,
        input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
        input logic we, input logic [1:0] addr, input logic sel, input logic [7:0] data,
        input logic [2:0] xs, input logic [23:0] xst, input logic [23:0] xc, input string nm);
        exp_t x;
        @(negedge clk);
        rst_n    = r;
        en       = e;
        current  = {c2, c1, c0};
        cfg_we   = we;
        cfg_addr = addr;
        cfg_sel  = sel;
        cfg_data = data;
        @(posedge clk);
        x.name = nm;
        x.spk  = xs;
        x.st   = xst;
        x.cnt  = xc;
        sb.push_back(x);
    endtask

    // Monitor: outputs are registered, so compare on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            checkOutput(x.name, "spike", {21'd0, spike}, {21'd0, x.spk});
            checkOutput(x.name, "state", state_out, x.st);
            checkOutput(x.name, "cnt",   cnt_out, x.cnt);
        end
    end

    initial begin
        int waitCycles;
        // Reset
        applyStimulus(0,1, 0,0,0, 1,0,0,8'd5, 3'b000, st3(0,0,0), cnt3(0,0,0), "reset0");
        applyStimulus(0,0, 0,0,0, 0,0,0,0,    3'b000, st3(0,0,0), cnt3(0,0,0), "reset1");

        // Integrate and fire, neuron 0, current 20
        applyStimulus(1,1, 20,0,0, 0,0,0,0, 3'b000, st3(20,0,0), cnt3(0,0,0), "int_e1");
        applyStimulus(1,1, 20,0,0, 0,0,0,0, 3'b000, st3(30,0,0), cnt3(0,0,0), "int_e2");
        applyStimulus(1,1, 20,0,0, 0,0,0,0, 3'b001, st3(0,0,0),  cnt3(1,0,0), "int_fire");
        applyStimulus(1,1, 20,0,0, 0,0,0,0, 3'b000, st3(0,0,0),  cnt3(1,0,0), "int_ref1");
        applyStimulus(1,1, 20,0,0, 0,0,0,0, 3'b000, st3(0,0,0),  cnt3(1,0,0), "int_ref2");
        applyStimulus(1,1, 20,0,0, 0,0,0,0, 3'b000, st3(20,0,0), cnt3(1,0,0), "int_e6");
        applyStimulus(1,1, 20,0,0, 0,0,0,0, 3'b000, st3(30,0,0), cnt3(1,0,0), "int_e7");

        // Enable low holds state
        for (int k = 0; k < 3; k++)
            applyStimulus(1,0, 20,0,0, 0,0,0,0, 3'b000, st3(30,0,0), cnt3(1,0,0), "en_hold");

        // Reset overrides en and cfg_we; thresholds back to 32
        applyStimulus(0,1, 20,0,0, 1,0,0,8'd5, 3'b000, st3(0,0,0),  cnt3(0,0,0), "rst_ovr");
        applyStimulus(1,1, 20,0,0, 0,0,0,0,    3'b000, st3(20,0,0), cnt3(0,0,0), "rst_thr1");
        applyStimulus(1,1, 20,0,0, 0,0,0,0,    3'b000, st3(30,0,0), cnt3(0,0,0), "rst_thr2");
        applyStimulus(1,1, 20,0,0, 0,0,0,0,    3'b001, st3(0,0,0),  cnt3(1,0,0), "rst_thr3");
        applyStimulus(1,1, 0,0,0,  0,0,0,0,    3'b000, st3(0,0,0),  cnt3(1,0,0), "ref_a");
        applyStimulus(1,1, 0,0,0,  0,0,0,0,    3'b000, st3(0,0,0),  cnt3(1,0,0), "ref_b");

        // Config collision: same-edge write uses old threshold
        applyStimulus(1,1, 20,0,0, 1,0,0,8'd10, 3'b000, st3(20,0,0), cnt3(1,0,0), "coll_old");
        applyStimulus(1,1, 20,0,0, 0,0,0,0,     3'b001, st3(0,0,0),  cnt3(2,0,0), "coll_new");
        applyStimulus(1,1, 0,0,0,  0,0,0,0,     3'b000, st3(0,0,0),  cnt3(2,0,0), "coll_r1");
        applyStimulus(1,1, 0,0,0,  0,0,0,0,     3'b000, st3(0,0,0),  cnt3(2,0,0), "coll_r2");

        // Out-of-range address ignored
        applyStimulus(1,0, 0,0,0, 1,2'd3,0,8'd0, 3'b000, st3(0,0,0), cnt3(2,0,0), "oob_wr");
        applyStimulus(1,1, 0,0,0, 0,0,0,0,       3'b000, st3(0,0,0), cnt3(2,0,0), "oob_chk");

        // Refractory zero on neuron 1
        applyStimulus(1,0, 0,0,0,  1,2'd1,1,8'd0, 3'b000, st3(0,0,0), cnt3(2,0,0), "rz_wr");
        applyStimulus(1,1, 0,40,0, 0,0,0,0,       3'b010, st3(0,0,0), cnt3(2,1,0), "rz_s1");
        applyStimulus(1,1, 0,40,0, 0,0,0,0,       3'b010, st3(0,0,0), cnt3(2,2,0), "rz_s2");
        applyStimulus(1,1, 0,40,0, 0,0,0,0,       3'b010, st3(0,0,0), cnt3(2,3,0), "rz_s3");
        applyStimulus(1,1, 0,0,0,  0,0,0,0,       3'b000, st3(0,0,0), cnt3(2,3,0), "rz_idle");

        // Saturation on neuron 2 with threshold 255
        applyStimulus(1,0, 0,0,0,   1,2'd2,0,8'd255, 3'b000, st3(0,0,0),   cnt3(2,3,0), "sat_wr");
        applyStimulus(1,1, 0,0,200, 0,0,0,0,         3'b000, st3(0,0,200), cnt3(2,3,0), "sat_e1");
        applyStimulus(1,1, 0,0,200, 0,0,0,0,         3'b100, st3(0,0,0),   cnt3(2,3,1), "sat_fire");
        applyStimulus(1,1, 0,0,0,   0,0,0,0,         3'b000, st3(0,0,0),   cnt3(2,3,1), "sat_r1");
        applyStimulus(1,1, 0,0,0,   0,0,0,0,         3'b000, st3(0,0,0),   cnt3(2,3,1), "sat_r2");

        // Counter saturation: neuron 2 threshold 0, refractory 0
        applyStimulus(0,0, 0,0,0, 0,0,0,0,       3'b000, st3(0,0,0), cnt3(0,0,0), "cnt_rst");
        applyStimulus(1,0, 0,0,0, 1,2'd2,0,8'd0, 3'b000, st3(0,0,0), cnt3(0,0,0), "cnt_thr");
        applyStimulus(1,0, 0,0,0, 1,2'd2,1,8'd0, 3'b000, st3(0,0,0), cnt3(0,0,0), "cnt_ref");
        for (int k = 1; k <= 300; k++)
            applyStimulus(1,1, 0,0,0, 0,0,0,0, 3'b100, st3(0,0,0),
                          cnt3(0,0,(k > 255) ? 8'd255 : 8'(k)), "cnt_run");

        // Drain the scoreboard with a bounded wait
        waitCycles = 0;
        while (sb.size() > 0 && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        @(posedge clk);
        if (sb.size() > 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drain pending %0d expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
